// File: rtl/deserializer_align_pkg.sv
// Shared types and constants for the deserializer word aligner.
// Optional error counter: ALIGN_ERRCNT_EN.
package deserializer_align_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      CHECK  = 2'd2,
      LOCKED = 2'd3
   } align_state_t;

   localparam logic [31:0] SYNC_DEFAULT = 32'h3C5A_A5C3;

   localparam int SETTLE_W = 4;
   localparam int MATCH_W  = 8;
   localparam int ERR_W    = 16;

endpackage

// File: rtl/deserializer_aligner_counter.sv
// Clear/increment counter with terminal compare and optional saturation.
// Clear wins over increment; in saturate mode the count holds at term.
module align_counter #(
   parameter int W   = 8,
   parameter bit SAT = 1'b0
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   input  logic [W-1:0] term,
   output logic [W-1:0] count,
   output logic         hit
);

   assign hit = (count == term);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc && !(SAT && hit)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/deserializer_aligner.sv
// Word-alignment FSM sweeping the deserializer bit delay until lock.
// ALIGN_ERRCNT_EN enables the saturating lock-loss mismatch counter.
module deserializer_aligner
   import deserializer_align_pkg::*;
#(
   parameter int WORDWIDTH = 32,
   parameter int WIDTH = 6,
   parameter logic [WORDWIDTH-1:0] SYNC_PATTERN = WORDWIDTH'(SYNC_DEFAULT),
   parameter int SETTLE_WORDS = 3,
   parameter int LOCK_COUNT = 8,
   parameter int UNLOCK_COUNT = 4
) (
   input  logic                 wordCK,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 realign,
   input  logic                 train,
   input  logic [WORDWIDTH-1:0] din,
   output logic [WIDTH-1:0]     delay,
   output logic                 locked,
   output logic                 searching,
   output logic                 scanFail,
   output logic [ERR_W-1:0]     errCount
);

   localparam logic [SETTLE_W-1:0] SETTLE_TERM = SETTLE_W'(SETTLE_WORDS - 1);
   localparam logic [MATCH_W-1:0]  MATCH_TERM  = MATCH_W'(LOCK_COUNT - 1);
   localparam logic [MATCH_W-1:0]  MISS_TERM   = MATCH_W'(UNLOCK_COUNT - 1);
   localparam logic [WIDTH-1:0]    DLY_LAST    = WIDTH'(WORDWIDTH - 1);

   align_state_t state;

   logic match;
   logic run;
   logic restart;
   logic step;
   logic settle_clr, settle_inc, settle_hit;
   logic match_clr, match_inc, match_hit;
   logic miss_clr, miss_inc, miss_hit;
   logic [SETTLE_W-1:0] settle_cnt;
   logic [MATCH_W-1:0]  match_cnt;
   logic [MATCH_W-1:0]  miss_cnt;

   assign match   = (din == SYNC_PATTERN);
   assign restart = enable & realign;
   assign run     = enable & ~realign;

   // Counter controls and delay-step decode for the current word.
   always_comb begin
      step       = 1'b0;
      settle_clr = restart;
      settle_inc = 1'b0;
      match_clr  = 1'b0;
      match_inc  = 1'b0;
      miss_clr   = 1'b0;
      miss_inc   = 1'b0;
      if (run) begin
         unique case (state)
            IDLE: settle_clr = 1'b1;
            SETTLE: begin
               if (settle_hit) match_clr = 1'b1;
               else settle_inc = 1'b1;
            end
            CHECK: begin
               if (!match) begin
                  step       = 1'b1;
                  settle_clr = 1'b1;
               end else if (match_hit) begin
                  miss_clr = 1'b1;
               end else begin
                  match_inc = 1'b1;
               end
            end
            LOCKED: begin
               if (train) begin
                  if (match) begin
                     miss_clr = 1'b1;
                  end else if (miss_hit) begin
                     step       = 1'b1;
                     settle_clr = 1'b1;
                     miss_clr   = 1'b1;
                  end else begin
                     miss_inc = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge wordCK or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         delay     <= '0;
         locked    <= 1'b0;
         searching <= 1'b0;
         scanFail  <= 1'b0;
      end else if (!enable) begin
         state     <= IDLE;
         locked    <= 1'b0;
         searching <= 1'b0;
      end else if (realign) begin
         state     <= SETTLE;
         delay     <= '0;
         locked    <= 1'b0;
         searching <= 1'b1;
         scanFail  <= 1'b0;
      end else begin
         // Wrap is modulo the word width, not the delay field width.
         if (step) begin
            if (delay == DLY_LAST) begin
               delay    <= '0;
               scanFail <= 1'b1;
            end else begin
               delay <= delay + WIDTH'(1);
            end
         end
         unique case (state)
            IDLE: begin
               state     <= SETTLE;
               searching <= 1'b1;
            end
            SETTLE: begin
               if (settle_hit) state <= CHECK;
            end
            CHECK: begin
               if (!match) begin
                  state <= SETTLE;
               end else if (match_hit) begin
                  state     <= LOCKED;
                  locked    <= 1'b1;
                  searching <= 1'b0;
                  scanFail  <= 1'b0;
               end
            end
            LOCKED: begin
               if (step) begin
                  state     <= SETTLE;
                  locked    <= 1'b0;
                  searching <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   align_counter #(.W(SETTLE_W), .SAT(1'b0)) u_settle (
      .clk   (wordCK),
      .reset (reset),
      .clr   (settle_clr),
      .inc   (settle_inc),
      .term  (SETTLE_TERM),
      .count (settle_cnt),
      .hit   (settle_hit)
   );

   align_counter #(.W(MATCH_W), .SAT(1'b0)) u_match (
      .clk   (wordCK),
      .reset (reset),
      .clr   (match_clr),
      .inc   (match_inc),
      .term  (MATCH_TERM),
      .count (match_cnt),
      .hit   (match_hit)
   );

   align_counter #(.W(MATCH_W), .SAT(1'b0)) u_miss (
      .clk   (wordCK),
      .reset (reset),
      .clr   (miss_clr),
      .inc   (miss_inc),
      .term  (MISS_TERM),
      .count (miss_cnt),
      .hit   (miss_hit)
   );

`ifdef ALIGN_ERRCNT_EN
   logic err_inc;
   logic err_full;

   assign err_inc = run & (state == LOCKED) & train & ~match & ~err_full;

   align_counter #(.W(ERR_W), .SAT(1'b1)) u_err (
      .clk   (wordCK),
      .reset (reset),
      .clr   (restart),
      .inc   (err_inc),
      .term  ({ERR_W{1'b1}}),
      .count (errCount),
      .hit   (err_full)
   );
`else
   assign errCount = '0;
`endif

endmodule

// File: tb/tb_deserializer_aligner.sv
// Directed scoreboard bench for deserializer_aligner.
// Expected errCount tracks ALIGN_ERRCNT_EN.
module tb_deserializer_aligner;

   localparam logic [31:0] SYNC = 32'h3C5A_A5C3;
   localparam int GOOD = 5;
`ifdef ALIGN_ERRCNT_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef enum int {S_DELAY, S_LOCKED, S_SEARCH, S_SCAN, S_ERR} sig_e;
   typedef struct {
      sig_e        sig;
      logic [31:0] val;
      string       tag;
   } exp_t;

   logic        wordCK = 1'b0;
   logic        reset;
   logic        enable;
   logic        realign;
   logic        train;
   logic [31:0] din;
   logic [5:0]  delay;
   logic        locked;
   logic        searching;
   logic        scanFail;
   logic [15:0] errCount;

   exp_t q[$];
   int   applied = 0;
   int   miss = 0;
   int   mode = 0;

   always #5 wordCK = ~wordCK;

   deserializer_aligner dut (
      .wordCK    (wordCK),
      .reset     (reset),
      .enable    (enable),
      .realign   (realign),
      .train     (train),
      .din       (din),
      .delay     (delay),
      .locked    (locked),
      .searching (searching),
      .scanFail  (scanFail),
      .errCount  (errCount)
   );

   // Deserializer model: word rotation follows the delay offset from GOOD.
   function automatic logic [31:0] model_din();
      int rot;
      logic [31:0] w;
      w = SYNC;
      case (mode)
         0: begin
            rot = (int'(delay) + 32 - GOOD) % 32;
            model_din = (w >> rot) | (w << (32 - rot));
         end
         1: model_din = 32'h0;
         2: model_din = $urandom;
         default: model_din = ~w;
      endcase
   endfunction

   function automatic logic [31:0] observe(sig_e s);
      case (s)
         S_DELAY:  observe = 32'(delay);
         S_LOCKED: observe = 32'(locked);
         S_SEARCH: observe = 32'(searching);
         S_SCAN:   observe = 32'(scanFail);
         default:  observe = 32'(errCount);
      endcase
   endfunction

   function automatic logic [31:0] errv(int n);
      errv = ERR_EN ? 32'(n) : 32'h0;
   endfunction

   task automatic push(sig_e s, logic [31:0] v, string tag);
      exp_t e;
      e.sig = s;
      e.val = v;
      e.tag = tag;
      q.push_back(e);
   endtask

   task automatic check_all();
      exp_t e;
      logic [31:0] o;
      while (q.size() > 0) begin
         e = q.pop_front();
         o = observe(e.sig);
         applied++;
         assert (o === e.val) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, o, e.val);
         end
      end
   endtask

   task automatic set_mode(int m);
      mode = m;
      din = model_din();
   endtask

   task automatic step(int n);
      repeat (n) begin
         @(negedge wordCK);
         din = model_din();
      end
   endtask

   initial begin
      reset = 1'b1;
      enable = 1'b0;
      realign = 1'b0;
      train = 1'b1;
      din = 32'h0;
      #2;
      push(S_DELAY, 0, "rst_delay");
      push(S_LOCKED, 0, "rst_locked");
      push(S_SEARCH, 0, "rst_search");
      push(S_SCAN, 0, "rst_scan");
      push(S_ERR, 0, "rst_err");
      check_all();

      // Initial sweep up to lock at delay 5
      @(negedge wordCK);
      reset = 1'b0;
      enable = 1'b1;
      set_mode(0);
      push(S_LOCKED, 0, "pre_lock_locked");
      push(S_DELAY, 5, "pre_lock_delay");
      push(S_SEARCH, 1, "pre_lock_search");
      step(31);
      check_all();
      push(S_LOCKED, 1, "lock_locked");
      push(S_SEARCH, 0, "lock_search");
      push(S_DELAY, 5, "lock_delay");
      push(S_SCAN, 0, "lock_scan");
      step(1);
      check_all();

      // Loss of lock after UNLOCK_COUNT mismatches
      set_mode(3);
      push(S_LOCKED, 1, "miss3_locked");
      push(S_DELAY, 5, "miss3_delay");
      push(S_ERR, errv(3), "miss3_err");
      step(3);
      check_all();
      push(S_LOCKED, 0, "miss4_locked");
      push(S_DELAY, 6, "miss4_delay");
      push(S_SEARCH, 1, "miss4_search");
      push(S_ERR, errv(4), "miss4_err");
      step(1);
      check_all();

      // enable low beats realign
      enable = 1'b0;
      realign = 1'b1;
      set_mode(0);
      push(S_LOCKED, 0, "dis_locked");
      push(S_SEARCH, 0, "dis_search");
      push(S_DELAY, 6, "dis_delay");
      push(S_ERR, errv(4), "dis_err");
      step(1);
      check_all();
      enable = 1'b1;
      push(S_DELAY, 0, "realign_delay");
      push(S_SCAN, 0, "realign_scan");
      push(S_SEARCH, 1, "realign_search");
      push(S_ERR, 0, "realign_err");
      step(1);
      check_all();
      realign = 1'b0;
      push(S_LOCKED, 1, "relock_locked");
      push(S_DELAY, 5, "relock_delay");
      step(31);
      check_all();

      // train gating and miss counter clearing
      set_mode(3);
      push(S_LOCKED, 1, "pre_gate_locked");
      push(S_ERR, errv(2), "pre_gate_err");
      step(2);
      check_all();
      train = 1'b0;
      set_mode(2);
      push(S_LOCKED, 1, "gate_locked");
      push(S_DELAY, 5, "gate_delay");
      push(S_ERR, errv(2), "gate_err");
      step(100);
      check_all();
      train = 1'b1;
      set_mode(0);
      step(1);
      set_mode(3);
      push(S_LOCKED, 1, "clr_miss_locked");
      push(S_ERR, errv(5), "clr_miss_err");
      step(3);
      check_all();
      set_mode(0);
      push(S_LOCKED, 1, "recover_locked");
      step(1);
      check_all();

      // No pattern: full sweep sets scanFail
      realign = 1'b1;
      set_mode(1);
      step(1);
      realign = 1'b0;
      push(S_DELAY, 31, "sweep_last_delay");
      push(S_SCAN, 0, "sweep_last_scan");
      push(S_SEARCH, 1, "sweep_search");
      step(127);
      check_all();
      push(S_DELAY, 0, "wrap_delay");
      push(S_SCAN, 1, "wrap_scan");
      step(1);
      check_all();
      push(S_DELAY, 11, "sweep300_delay");
      push(S_LOCKED, 0, "sweep300_locked");
      push(S_SCAN, 1, "sweep300_scan");
      push(S_SEARCH, 1, "sweep300_search");
      step(172);
      check_all();

      // Asynchronous reset mid-SETTLE
      #2;
      reset = 1'b1;
      #1;
      push(S_DELAY, 0, "async_delay");
      push(S_SCAN, 0, "async_scan");
      push(S_SEARCH, 0, "async_search");
      push(S_LOCKED, 0, "async_locked");
      push(S_ERR, 0, "async_err");
      check_all();
      @(negedge wordCK);
      reset = 1'b0;
      set_mode(0);
      push(S_LOCKED, 1, "post_rst_locked");
      push(S_DELAY, 5, "post_rst_delay");
      push(S_SCAN, 0, "post_rst_scan");
      step(32);
      check_all();

      $display("== %0d vectors applied, %0d miscompares ==", applied, miss);
      $finish;
   end

endmodule

// File: doc/deserializer_aligner.md
# deserializer_aligner

Word-alignment controller for the LSB-first deserializer in the ETROC2 readout path. Runs in the word-clock domain, compares each deserialized word against a fixed training pattern, and sweeps the deserializer's bit `delay` setting until the pattern is seen on LOCK_COUNT consecutive words. Once locked, it monitors training words and re-enters the search when alignment is lost. Its `delay` output drives the deserializer's `delay` input directly.

## Interface
- WORDWIDTH, 32: deserialized word width.
- WIDTH, 6: width of `delay`; must satisfy 2^WIDTH >= WORDWIDTH.
- SYNC_PATTERN, 32'h3C5A_A5C3: training word, WORDWIDTH bits.
- SETTLE_WORDS, 3: words discarded after every `delay` change; range 1..15.
- LOCK_COUNT, 8: consecutive matches required to lock; range 1..255.
- UNLOCK_COUNT, 4: consecutive training-word mismatches that drop lock; range 1..255.

Ports:
- wordCK  in  1  sole clock; the deserializer word clock. All logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  run the alignment; low forces IDLE.
- realign  in  1  single-cycle request to restart the search from delay 0.
- train  in  1  high while the far end transmits SYNC_PATTERN; qualifies mismatches in LOCKED.
- din  in  WORDWIDTH  deserializer `dout`.
- delay  out  WIDTH  bit-delay setting for the deserializer.
- locked  out  1  alignment achieved.
- searching  out  1  high in SETTLE or CHECK.
- scanFail  out  1  sticky; a full 0..WORDWIDTH-1 sweep completed without lock.
- errCount  out  16  saturating lock-loss mismatch count; see Configuration.

## Operation
- States: IDLE, SETTLE, CHECK, LOCKED.
- Reset: state=IDLE, delay=0, locked=0, searching=0, scanFail=0, errCount=0, all internal counters=0.
- IDLE: delay holds its value. When enable=1, go to SETTLE with settleCnt=0.
- SETTLE: settleCnt increments each word. When settleCnt reaches SETTLE_WORDS-1, go to CHECK with matchCnt=0. The value on din is ignored in SETTLE.
- CHECK:
  - din==SYNC_PATTERN: matchCnt increments. If this is the LOCK_COUNT-th consecutive match, go to LOCKED and clear scanFail.
  - Mismatch: step the delay and go to SETTLE.
- Delay step: delay = delay+1. If delay==WORDWIDTH-1, it wraps to 0 and scanFail is set. The wrap is modulo WORDWIDTH, not 2^WIDTH.
- LOCKED:
  - locked=1.
  - With train=1, a mismatch increments missCnt and a match clears missCnt.
  - With train=0, missCnt holds and din is ignored.
  - When missCnt reaches UNLOCK_COUNT: step the delay, go to SETTLE, locked=0.
- Priority on each edge: enable=0 wins over realign, which wins over normal transitions.
  - enable=0: next state IDLE, locked=0, delay held.
  - realign=1 with enable=1: delay=0, scanFail=0, errCount=0, go to SETTLE.
- locked = (state==LOCKED), registered. searching = state in {SETTLE, CHECK}, registered.
- Counter widths: settleCnt 4 bits; matchCnt and missCnt 8 bits. No counter may overflow within its parameter range.

## Timing
- Every output is registered and updates on the wordCK edge that performs the transition.
- The deserializer output reflects a new delay only after up to two word periods. SETTLE_WORDS>=3 covers this latency.
- Lock latency with the correct delay already applied, measured from the enable rising edge: 1 + SETTLE_WORDS + LOCK_COUNT words until locked=1.
- A mismatch in CHECK costs SETTLE_WORDS + 1 words before the next delay is evaluated.
- Worst-case search time: WORDWIDTH × (SETTLE_WORDS + LOCK_COUNT) words.
- Asserting reset mid-sweep returns all outputs to their reset values immediately (asynchronous). Operation resumes at delay 0 on the first edge after reset deasserts.

## Configuration
- ALIGN_ERRCNT_EN defined:
  - errCount increments on each qualified mismatch in LOCKED (train=1). It saturates at 16'hFFFF.
  - It is cleared by reset or realign and is not cleared by a lock loss.
- ALIGN_ERRCNT_EN undefined: errCount is tied to 0 and no counter logic is synthesized. The port list is identical in both builds.

## Structure
- Package `deserializer_align_pkg`:
  - the state enum (IDLE, SETTLE, CHECK, LOCKED);
  - the default SYNC_PATTERN;
  - the counter-width constants.
- One sub-module, `align_counter`: a parameterised-width counter with clear, increment, terminal-compare, and an optional saturate mode.
  - Instantiated for settleCnt, matchCnt and missCnt.
  - errCount uses it in saturate mode.
- The FSM and the delay stepping stay in the top module.

## Test plan
- Lock at offset: serializer shifted so delay=5 aligns, enable=1 from reset → delay steps 0..5, locked=1 exactly 1+6×(3+1)−… after the sweep, i.e. 3+8 words after delay reaches 5; searching=0 thereafter.
- No pattern present: din constant 0 for 300 words → delay wraps 31→0, scanFail=1 after 32×4 words, locked stays 0.
- Loss of lock: locked at delay=5, then inject 3 mismatches → still locked, errCount=3; a 4th mismatch → locked=0, delay=6, errCount=4 (macro defined) or 0 (undefined).
- train gating: locked, train=0, random din for 100 words → locked stays 1, errCount unchanged.
- realign/enable priority: realign=1 and enable=0 on the same edge → IDLE, delay held. Then realign with enable=1 → delay=0, scanFail=0, SETTLE.
- Reset mid-operation: assert reset between edges during SETTLE → all outputs 0 immediately, before the next wordCK edge.
